mux_n_1_arb: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes, successor to the fixed 4:1 gate-level mux. Selects one input channel per beat, either by an external select (fixed mode) or by round-robin arbitration, and holds the grant for a whole packet, delimited by `in_last`. Sits between multiple producers and a single downstream consumer. Output is registered, giving a 1-cycle latency at full throughput.

---
 rtl/mux_n_1_arb_pkg.sv | 12 +
 rtl/mux_n_1_arb_if.sv | 32 +++
 rtl/mux_n_1_arb_rr_pick.sv | 28 ++
 rtl/mux_n_1_arb.sv | 107 ++++++++++
 4 files changed

// File: rtl/mux_n_1_arb_pkg.sv
// Shared types and helpers for the N:1 registered arbitrating mux.
package mux_arb_pkg;

    typedef enum logic { MODE_FIXED = 1'b0, MODE_RR = 1'b1 } mux_mode_e;
    typedef enum logic { ARB = 1'b0, LOCK = 1'b1 } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_arb_if.sv
// Producer-side and consumer-side handshake bundle for mux_n_1_arb.
interface mux_n_1_arb_if
    import mux_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = clog2_min1(N_CH);

    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;
    mux_mode_e              mode;
    logic [SEL_W-1:0]       sel;
    logic [DATA_W-1:0]      out_data;
    logic                   out_last;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, in_last, mode, sel, out_ready,
        input  in_ready, out_data, out_last, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, mode, sel, out_ready,
        output in_ready, out_data, out_last, out_ch, out_valid
    );

endinterface

// File: rtl/mux_n_1_arb_rr_pick.sv
// Combinational finder: first set request at or after start, wrapping.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            int c;
            c = int'(start) + i;
            if (c >= N_CH) c = c - N_CH;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_arb.sv
// N:1 registered mux with fixed-select or round-robin arbitration and
// packet-level grant locking delimited by in_last.
module mux_n_1_arb
    import mux_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    mux_n_1_arb_if.slave bus
);

    localparam int SEL_W = clog2_min1(N_CH);

    arb_state_e       state, state_nxt;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0] lock_ch, lock_ch_nxt;

    logic             can_load;
    logic             have_gnt;
    logic [SEL_W-1:0] gnt_ch;
    logic             xfer;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;

    assign can_load = !bus.out_valid || bus.out_ready;

    rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr_pick (
        .req   (bus.in_valid),
        .start (rr_ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    // Grant selection, ready generation and next-state.
    always_comb begin
        have_gnt    = 1'b0;
        gnt_ch      = '0;
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_ch_nxt = lock_ch;
        bus.in_ready = '0;

        case (state)
            LOCK: begin
                // Locked grant does not look at valid, so ready stays put.
                have_gnt = 1'b1;
                gnt_ch   = lock_ch;
            end
            default: begin
                if (bus.mode == MODE_RR) begin
                    have_gnt = rr_found;
                    gnt_ch   = rr_idx;
                end else if (int'(bus.sel) < N_CH) begin
                    have_gnt = bus.in_valid[bus.sel];
                    gnt_ch   = bus.sel;
                end
            end
        endcase

        if (rst_n && have_gnt && can_load)
            bus.in_ready = N_CH'(1) << gnt_ch;

        xfer = rst_n && have_gnt && can_load && bus.in_valid[gnt_ch];

        if (xfer) begin
            if (!bus.in_last[gnt_ch]) begin
                state_nxt   = LOCK;
                lock_ch_nxt = gnt_ch;
            end else begin
                state_nxt = ARB;
                if (bus.mode == MODE_RR)
                    rr_ptr_nxt = (int'(gnt_ch) == N_CH - 1) ? '0 : gnt_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[gnt_ch*DATA_W +: DATA_W];
            bus.out_last  <= bus.in_last[gnt_ch];
            bus.out_ch    <= gnt_ch;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
